// File: rtl/coin_key_filter_if.sv
`default_nettype none
// ---- coin_key_filter_if : raw key inputs and clean coin pulses -- rev 1.0 ----
interface coin_key_filter_if;
  logic keyOne;
  logic keyHalf;
  logic poOne;
  logic poHalf;

  modport master (output keyOne, output keyHalf, input poOne, input poHalf);
  modport slave  (input keyOne, input keyHalf, output poOne, output poHalf);
endinterface
`default_nettype wire

// File: rtl/coin_key_filter.sv
`default_nettype none
// ---- coin_key_filter : debounced, arbitrated one-cycle coin pulses -- rev 1.0 ----
module coin_key_filter #(
  parameter int CNT_MAX = 1_000_000
) (
  input  logic              sys_clk,
  input  logic              sysRstN,
  coin_key_filter_if.slave  key_if
);

  localparam logic [19:0] CNT_LAST = 20'(CNT_MAX - 1);

  // Channel 0 is the one-yuan key, channel 1 the half-yuan key.
  logic [1:0] key_raw;
  logic [1:0] req;

  assign key_raw = {key_if.keyHalf, key_if.keyOne};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stable_q, stable_d;
    logic [19:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d  = key_raw[g];
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end

    // Only an accepted press (falling stable level) raises a request.
    assign req[g] = stable_q & ~stable_d;

    always_ff @(posedge sys_clk or negedge sysRstN) begin
      if (!sysRstN) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  arb_state_e state_q, state_d;
  logic       pend_one_q, pend_one_d;
  logic       pend_half_q, pend_half_d;
  logic       po_one_q, po_one_d;
  logic       po_half_q, po_half_d;
  logic       want_one, want_half;

  always_comb begin
    want_one  = 1'b0;
    want_half = 1'b0;
    case (state_q)
      ST_IDLE: begin
        want_one  = req[0];
        want_half = req[1];
      end
      ST_HOLD: begin
        want_one  = req[0] | pend_one_q;
        want_half = req[1] | pend_half_q;
      end
      default: begin
        want_one  = 1'b0;
        want_half = 1'b0;
      end
    endcase
    // ONE wins a collision; the losing HALF request waits one cycle.
    po_one_d    = want_one;
    po_half_d   = want_half & ~want_one;
    pend_one_d  = want_one & ~po_one_d;
    pend_half_d = want_half & ~po_half_d;
    state_d     = (pend_one_d | pend_half_d) ? ST_HOLD : ST_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q     <= ST_IDLE;
      pend_one_q  <= 1'b0;
      pend_half_q <= 1'b0;
      po_one_q    <= 1'b0;
      po_half_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_one_q  <= pend_one_d;
      pend_half_q <= pend_half_d;
      po_one_q    <= po_one_d;
      po_half_q   <= po_half_d;
    end
  end

  assign key_if.poOne  = po_one_q;
  assign key_if.poHalf = po_half_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_key_filter.sv
`default_nettype none
// ---- tb_coin_key_filter : scoreboard bench for coin_key_filter (CNT_MAX=4) -- rev 1.0 ----
module tb_coin_key_filter;

  logic sys_clk = 1'b0;
  logic sysRstN = 1'b1;

  coin_key_filter_if bus ();

  coin_key_filter #(.CNT_MAX(4)) dut (
    .sys_clk (sys_clk),
    .sysRstN (sysRstN),
    .key_if  (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   empty_req  = 0;
  int   empty_srv  = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per observed pulse; ch 0 = ONE, 1 = HALF.
  initial begin : monitor
    exp_t e;
    int   act_ch;
    forever begin
      @(negedge sys_clk);
      if (!sysRstN) begin
        compared++;
        if (bus.poOne !== 1'b0 || bus.poHalf !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_clear: poOne=%b poHalf=%b required 0 0 (cyc %0d)",
                   bus.poOne, bus.poHalf, cyc);
        end
      end else begin
        compared++;
        if (bus.poOne === 1'b1 && bus.poHalf === 1'b1) begin
          mismatched++;
          $display("FAIL exclusive: both pulses high at cyc %0d, required at most one", cyc);
        end
        if (bus.poOne === 1'b1 || bus.poHalf === 1'b1) begin
          act_ch = (bus.poOne === 1'b1) ? 0 : 1;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: ch %0d at cyc %0d, required no pulse", act_ch, cyc);
          end else begin
            e = exp_q.pop_front();
            if (act_ch != e.ch || cyc != e.cyc) begin
              mismatched++;
              $display("FAIL pulse_match: got ch %0d cyc %0d, required ch %0d cyc %0d",
                       act_ch, cyc, e.ch, e.cyc);
            end
          end
        end
      end
      if (empty_req != empty_srv) begin
        empty_srv = empty_req;
        compared++;
        if (exp_q.size() != 0) begin
          mismatched++;
          $display("FAIL missing_pulse: %0d outstanding, next ch %0d cyc %0d, required 0 outstanding",
                   exp_q.size(), exp_q[0].ch, exp_q[0].cyc);
          exp_q.delete();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int ch, input int c);
    exp_t t;
    t.ch  = ch;
    t.cyc = c;
    exp_q.push_back(t);
  endtask

  task automatic check_empty();
    empty_req++;
    tick(2);
  endtask

  // Returns just after the rising edge numbered t.
  task automatic wait_edge(input int t);
    while (cyc != t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int t;
    bus.keyOne  = 1'b1;
    bus.keyHalf = 1'b1;
    #1 sysRstN = 1'b0;
    tick(3);
    #1 sysRstN = 1'b1;
    tick(2);

    // Clean press on ONE: E0 = cyc+1, pulse seen after E5.
    bus.keyOne = 1'b0;
    push(0, cyc + 6);
    tick(20);
    bus.keyOne = 1'b1;
    tick(12);
    check_empty();

    // Bounce on HALF, then steady low.
    for (int i = 0; i < 3; i++) begin
      bus.keyHalf = 1'b0;
      tick(2);
      bus.keyHalf = 1'b1;
      tick(2);
    end
    bus.keyHalf = 1'b0;
    push(1, cyc + 6);
    tick(12);
    bus.keyHalf = 1'b1;
    tick(12);
    check_empty();

    // Simultaneous press: HALF is delayed by one cycle.
    bus.keyOne  = 1'b0;
    bus.keyHalf = 1'b0;
    push(0, cyc + 6);
    push(1, cyc + 7);
    tick(12);
    bus.keyOne  = 1'b1;
    bus.keyHalf = 1'b1;
    tick(12);
    check_empty();

    // 3-cycle glitch on ONE is rejected.
    bus.keyOne = 1'b0;
    tick(3);
    bus.keyOne = 1'b1;
    tick(15);
    check_empty();

    // Reset while cnt == 2 (just after E3), key held through release.
    bus.keyOne = 1'b0;
    t = cyc + 4;
    wait_edge(t);
    sysRstN = 1'b0;
    @(negedge sys_clk);
    #1 sysRstN = 1'b1;
    push(0, cyc + 6);
    tick(12);
    bus.keyOne = 1'b1;
    tick(12);
    check_empty();

    // Reset during the HALF pulse cycle clears it asynchronously; held key re-fires.
    bus.keyHalf = 1'b0;
    t = cyc + 6;
    wait_edge(t);
    sysRstN = 1'b0;
    @(negedge sys_clk);
    #1 sysRstN = 1'b1;
    push(1, cyc + 6);
    tick(12);
    bus.keyHalf = 1'b1;
    tick(12);
    check_empty();

    // Three press/release cycles on HALF, pulses 16 cycles apart.
    for (int i = 0; i < 3; i++) begin
      bus.keyHalf = 1'b0;
      push(1, cyc + 6);
      tick(8);
      bus.keyHalf = 1'b1;
      tick(8);
    end
    tick(4);
    check_empty();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
